cpu_sequencer: RTL and testbench



---
 rtl/cpu_sequencer.sv | 162 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// cpu_sequencer : 8-phase control sequencer and opcode decoder, Moore outputs
// Revision      : 1.0
// ============================================================================
module cpu_sequencer #(
  parameter int             OPW    = 3,
  parameter logic [OPW-1:0] HLT_OP = 3'd0,
  parameter logic [OPW-1:0] SKZ_OP = 3'd1,
  parameter logic [OPW-1:0] STO_OP = 3'd6,
  parameter logic [OPW-1:0] JMP_OP = 3'd7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           pc_addr,
  output logic           pc_actve,
  output logic           rd,
  output logic           wr,
  output logic           ld_ir,
  output logic           ld_ac,
  output logic           inc_pc,
  output logic           ld_pc,
  output logic           data_e,
  output logic           halt,
  output logic [2:0]     phase
);

  localparam logic [3:0] S_INST_ADDR  = 4'd0;
  localparam logic [3:0] S_INST_FETCH = 4'd1;
  localparam logic [3:0] S_INST_LOAD  = 4'd2;
  localparam logic [3:0] S_IDLE       = 4'd3;
  localparam logic [3:0] S_OP_ADDR    = 4'd4;
  localparam logic [3:0] S_OP_FETCH   = 4'd5;
  localparam logic [3:0] S_ALU_OP     = 4'd6;
  localparam logic [3:0] S_STORE      = 4'd7;
  localparam logic [3:0] S_HALTED     = 4'd8;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_alu, w_sto, w_jmp, w_skz;
  logic       w_pc_addr, w_pc_actve, w_rd, w_wr, w_ld_ir, w_ld_ac;
  logic       w_inc_pc, w_ld_pc, w_data_e, w_halt;
  logic [2:0] w_phase;
  logic       r_pc_addr, r_pc_actve, r_rd, r_wr, r_ld_ir, r_ld_ac;
  logic       r_inc_pc, r_ld_pc, r_data_e, r_halt;
  logic [2:0] r_phase;

  assign w_sto = (opcode == STO_OP);
  assign w_jmp = (opcode == JMP_OP);
  assign w_skz = (opcode == SKZ_OP);
  assign w_alu = !(w_sto || w_jmp || w_skz || (opcode == HLT_OP));

  // Reset folds into next-state so the decoded outputs on that edge are the phase-0 row.
  always_comb begin
    w_next = r_state;
    if (!rst_n)
      w_next = S_INST_ADDR;
    else if (r_state == S_HALTED)
      w_next = S_HALTED;
    else if ((r_state == S_OP_ADDR) && (opcode == HLT_OP))
      w_next = S_HALTED;
    else
      w_next = {1'b0, r_state[2:0] + 3'd1};
  end

  always_comb begin
    w_pc_addr  = 1'b0;
    w_pc_actve = 1'b0;
    w_rd       = 1'b0;
    w_wr       = 1'b0;
    w_ld_ir    = 1'b0;
    w_ld_ac    = 1'b0;
    w_inc_pc   = 1'b0;
    w_ld_pc    = 1'b0;
    w_data_e   = 1'b0;
    w_halt     = 1'b0;
    w_phase    = w_next[2:0];
    case (w_next)
      S_INST_ADDR: begin
        w_pc_actve = 1'b1;
      end
      S_INST_FETCH: begin
        w_pc_actve = 1'b1;
        w_rd       = 1'b1;
      end
      S_INST_LOAD: begin
        w_pc_actve = 1'b1;
        w_rd       = 1'b1;
        w_ld_ir    = 1'b1;
      end
      S_IDLE: begin
        w_rd       = 1'b1;
        w_ld_ir    = 1'b1;
      end
      S_OP_ADDR: begin
        w_pc_actve = 1'b1;
        w_pc_addr  = 1'b1;
        w_inc_pc   = 1'b1;
      end
      S_OP_FETCH: begin
        w_pc_actve = 1'b1;
        w_pc_addr  = 1'b1;
        w_rd       = w_alu;
      end
      S_ALU_OP: begin
        w_pc_actve = 1'b1;
        w_pc_addr  = 1'b1;
        w_rd       = w_alu;
        w_inc_pc   = w_skz && zero;
        w_ld_pc    = w_jmp;
        w_data_e   = w_sto;
      end
      S_STORE: begin
        w_pc_actve = 1'b1;
        w_pc_addr  = 1'b1;
        w_rd       = w_alu;
        w_ld_ac    = w_alu;
        w_ld_pc    = w_jmp;
        w_wr       = w_sto;
        w_data_e   = w_sto;
      end
      S_HALTED: begin
        w_halt     = 1'b1;
        w_phase    = 3'd4;
      end
      default: begin
        w_phase    = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    r_state    <= w_next;
    r_pc_addr  <= w_pc_addr;
    r_pc_actve <= w_pc_actve;
    r_rd       <= w_rd;
    r_wr       <= w_wr;
    r_ld_ir    <= w_ld_ir;
    r_ld_ac    <= w_ld_ac;
    r_inc_pc   <= w_inc_pc;
    r_ld_pc    <= w_ld_pc;
    r_data_e   <= w_data_e;
    r_halt     <= w_halt;
    r_phase    <= w_phase;
  end

  assign pc_addr  = r_pc_addr;
  assign pc_actve = r_pc_actve;
  assign rd       = r_rd;
  assign wr       = r_wr;
  assign ld_ir    = r_ld_ir;
  assign ld_ac    = r_ld_ac;
  assign inc_pc   = r_inc_pc;
  assign ld_pc    = r_ld_pc;
  assign data_e   = r_data_e;
  assign halt     = r_halt;
  assign phase    = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_cpu_sequencer : self-checking bench with a phase-table reference model
// Revision         : 1.0
// ============================================================================
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       r_rstn = 1'b0;
  logic [2:0] r_op = 3'd2;
  logic       r_z = 1'b0;
  logic       pc_addr, pc_actve, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;
  logic [2:0] phase;
  logic [12:0] w_got;

  int         total = 0;
  int         bad = 0;
  int         m_ph = 0;
  bit         m_halt = 1'b0;
  logic [12:0] exp_v;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .rst_n(r_rstn), .opcode(r_op), .zero(r_z),
    .pc_addr(pc_addr), .pc_actve(pc_actve), .rd(rd), .wr(wr),
    .ld_ir(ld_ir), .ld_ac(ld_ac), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .data_e(data_e), .halt(halt), .phase(phase)
  );

  // {halt, pc_actve, pc_addr, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, phase}
  assign w_got = {halt, pc_actve, pc_addr, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, phase};

  function automatic logic [12:0] model_out(int ph, bit halted, logic [2:0] op, logic z);
    bit alu, sto, jmp, skz;
    logic pact, pa, rdv, wrv, ir, ac, inc, ldpc, de;
    if (halted) return {1'b1, 9'b0, 3'd4};
    sto  = (op == 3'd6);
    jmp  = (op == 3'd7);
    skz  = (op == 3'd1);
    alu  = !(op == 3'd0 || skz || sto || jmp);
    pact = (ph != 3);
    pa   = (ph >= 4);
    rdv  = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    wrv  = (ph == 7) && sto;
    ir   = (ph == 2) || (ph == 3);
    ac   = (ph == 7) && alu;
    inc  = (ph == 4) || (ph == 6 && skz && z);
    ldpc = (ph >= 6) && jmp;
    de   = (ph >= 6) && sto;
    return {1'b0, pact, pa, rdv, wrv, ir, ac, inc, ldpc, de, 3'(ph)};
  endfunction

  // Drive inputs, let one edge pass, advance the model, and stop on the falling edge.
  task automatic step(input logic [2:0] op, input logic z, input logic rn);
    r_op = op; r_z = z; r_rstn = rn;
    @(posedge clk);
    if (!rn) begin
      m_ph = 0; m_halt = 1'b0;
    end else if (!m_halt) begin
      if (m_ph == 4 && op == 3'd0) m_halt = 1'b1;
      else m_ph = (m_ph + 1) % 8;
    end
    exp_v = model_out(m_ph, m_halt, op, z);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(3'd2, 1'b0, 1'b0);
    step(3'd2, 1'b0, 1'b0);
    total++;
    if (w_got !== 13'b0_1_0_0_0_0_0_0_0_0_000) begin
      bad++; $display("FAIL reset_state got=%b exp=%b", w_got, 13'b0100000000000);
    end
  endtask

  task automatic test_alu();
    logic [2:0] ops [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
    for (int i = 0; i < 32; i++) begin
      step(ops[i / 8], 1'($urandom_range(0, 1)), 1'b1);
      total++;
      if (w_got !== exp_v) begin
        bad++; $display("FAIL alu_cycle i=%0d got=%b exp=%b", i, w_got, exp_v);
      end
    end
  endtask

  task automatic test_sto();
    int wr_cnt = 0;
    step(3'd6, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(3'd6, 1'($urandom_range(0, 1)), 1'b1);
      if (wr) wr_cnt++;
      total++;
      if (w_got !== exp_v) begin
        bad++; $display("FAIL sto_cycle i=%0d got=%b exp=%b", i, w_got, exp_v);
      end
    end
    total++;
    if (wr_cnt !== 2) begin
      bad++; $display("FAIL sto_wr_count got=%0d exp=2", wr_cnt);
    end
  endtask

  task automatic test_skz();
    int inc_cnt;
    for (int zz = 0; zz < 2; zz++) begin
      inc_cnt = 0;
      step(3'd1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
        step(3'd1, 1'(zz), 1'b1);
        if (inc_pc) inc_cnt++;
        total++;
        if (w_got !== exp_v) begin
          bad++; $display("FAIL skz_cycle z=%0d i=%0d got=%b exp=%b", zz, i, w_got, exp_v);
        end
      end
      total++;
      if (inc_cnt !== (zz ? 2 : 1)) begin
        bad++; $display("FAIL skz_inc_count z=%0d got=%0d exp=%0d", zz, inc_cnt, zz ? 2 : 1);
      end
    end
  endtask

  task automatic test_jmp();
    step(3'd7, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(3'd7, 1'($urandom_range(0, 1)), 1'b1);
      total++;
      if (w_got !== exp_v) begin
        bad++; $display("FAIL jmp_cycle i=%0d got=%b exp=%b", i, w_got, exp_v);
      end
    end
  endtask

  task automatic test_hlt();
    step(3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
      total++;
      if (w_got !== 13'b1_000000000_100) begin
        bad++; $display("FAIL hlt_hold i=%0d got=%b exp=%b", i, w_got, 13'b1000000000100);
      end
    end
    step(3'd2, 1'b0, 1'b0);
    total++;
    if (halt !== 1'b0 || phase !== 3'd0) begin
      bad++; $display("FAIL hlt_exit got halt=%b phase=%0d exp halt=0 phase=0", halt, phase);
    end
  endtask

  task automatic test_reset_mid();
    step(3'd6, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(3'd6, 1'b0, 1'b1);
    step(3'd6, 1'b0, 1'b0);
    total++;
    if (wr !== 1'b0 || phase !== 3'd0 || data_e !== 1'b0) begin
      bad++; $display("FAIL reset_mid got wr=%b phase=%0d data_e=%b exp wr=0 phase=0 data_e=0",
                      wr, phase, data_e);
    end
    step(3'd6, 1'b0, 1'b1);
    total++;
    if (w_got !== exp_v) begin
      bad++; $display("FAIL reset_mid_resume got=%b exp=%b", w_got, exp_v);
    end
  endtask

  task automatic test_random();
    step(3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) != 0));
      total++;
      if (w_got !== exp_v || (rd && wr)) begin
        bad++; $display("FAIL random_cycle i=%0d got=%b exp=%b", i, w_got, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_sto();
    test_skz();
    test_jmp();
    test_hlt();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
